// File: rtl/ppu_pkg.sv
// Shared PPU definitions: second-operand select encodings, ALU op width and
// the control pattern that marks an ID/EX slot as a bubble.
package ppu_pkg;

  typedef enum logic [2:0] {
    SEL_PB    = 3'd0,
    SEL_IMM_I = 3'd1,
    SEL_IMM_S = 3'd2,
    SEL_IMM_U = 3'd3,
    SEL_PC    = 3'd4,
    SEL_ZERO  = 3'd5
  } s2_sel_e;

  localparam int ALU_OP_W = 4;
  localparam logic [ALU_OP_W-1:0] ALU_NOP = '0;

  typedef struct packed {
    logic                valid;
    logic                rf_enable;
    logic                mem_load;
    logic                mem_write;
    logic                mem_se;
    logic [1:0]          mem_size;
    logic [ALU_OP_W-1:0] alu_op;
    logic [4:0]          rd;
    logic [2:0]          s2;
  } ctrl_t;

  // A bubble writes nothing, touches no memory and drives a zero second operand.
  localparam ctrl_t BUBBLE_CTRL = '{
    valid:     1'b0,
    rf_enable: 1'b0,
    mem_load:  1'b0,
    mem_write: 1'b0,
    mem_se:    1'b0,
    mem_size:  2'd0,
    alu_op:    ALU_NOP,
    rd:        5'd0,
    s2:        SEL_ZERO
  };

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and hold; never wraps.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             hold,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state is written with <= only, so every always_ff reads
  // the pre-edge value of its own registers regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (!hold && inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: registers decoded operands, raw immediates and
// control, with stall (hold), flush (bubble) and a saturating bubble counter.
module id_ex_pipeline_reg
  import ppu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_PA,
  input  logic [XLEN-1:0]  id_PB,
  input  logic [XLEN-1:0]  id_PC,
  input  logic [11:0]      id_imm12_I,
  input  logic [11:0]      id_imm12_S,
  input  logic [19:0]      id_imm20,
  input  logic [2:0]       id_S2,
  input  logic [3:0]       id_ALU_op,
  input  logic [4:0]       id_rd,
  input  logic             id_RF_enable,
  input  logic             id_mem_load,
  input  logic             id_mem_write,
  input  logic             id_mem_se,
  input  logic [1:0]       id_mem_size,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_PA,
  output logic [XLEN-1:0]  ex_PB,
  output logic [XLEN-1:0]  ex_PC,
  output logic [11:0]      ex_imm12_I,
  output logic [11:0]      ex_imm12_S,
  output logic [19:0]      ex_imm20,
  output logic [2:0]       ex_S2,
  output logic [3:0]       ex_ALU_op,
  output logic [4:0]       ex_rd,
  output logic             ex_RF_enable,
  output logic             ex_mem_load,
  output logic             ex_mem_write,
  output logic             ex_mem_se,
  output logic [1:0]       ex_mem_size,
  output logic [CNT_W-1:0] bubble_count
);

  ctrl_t ex_ctrl;

  // Bubbles that count: flush, or an empty decode slot that is not stalled.
  logic load_bubble;
  logic holding;

  assign load_bubble = flush || (!stall && !id_valid);
  assign holding     = stall && !flush;

  always_ff @(posedge clk) begin
    if (reset || load_bubble) begin
      ex_ctrl    <= BUBBLE_CTRL;
      ex_PA      <= '0;
      ex_PB      <= '0;
      ex_PC      <= '0;
      ex_imm12_I <= '0;
      ex_imm12_S <= '0;
      ex_imm20   <= '0;
    end else if (!stall) begin
      ex_ctrl    <= '{
        valid:     1'b1,
        rf_enable: id_RF_enable,
        mem_load:  id_mem_load,
        mem_write: id_mem_write,
        mem_se:    id_mem_se,
        mem_size:  id_mem_size,
        alu_op:    id_ALU_op,
        rd:        id_rd,
        s2:        id_S2
      };
      ex_PA      <= id_PA;
      ex_PB      <= id_PB;
      ex_PC      <= id_PC;
      ex_imm12_I <= id_imm12_I;
      ex_imm12_S <= id_imm12_S;
      ex_imm20   <= id_imm20;
    end
  end

  assign ex_valid     = ex_ctrl.valid;
  assign ex_RF_enable = ex_ctrl.rf_enable;
  assign ex_mem_load  = ex_ctrl.mem_load;
  assign ex_mem_write = ex_ctrl.mem_write;
  assign ex_mem_se    = ex_ctrl.mem_se;
  assign ex_mem_size  = ex_ctrl.mem_size;
  assign ex_ALU_op    = ex_ctrl.alu_op;
  assign ex_rd        = ex_ctrl.rd;
  assign ex_S2        = ex_ctrl.s2;

  // Reset-loaded bubbles are not counted: the counter's own clear wins.
  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (load_bubble),
    .hold  (holding),
    .count (bubble_count)
  );

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Scoreboard bench for id_ex_pipeline_reg: a driver pushes expected EX state
// from a behavioural model; a negedge monitor pops and compares.
module tb_id_ex_pipeline_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pa;
    logic [31:0] pb;
    logic [31:0] pc;
    logic [11:0] imm_i;
    logic [11:0] imm_s;
    logic [19:0] imm20;
    logic [2:0]  s2;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic        rf_en;
    logic        mem_load;
    logic        mem_write;
    logic        mem_se;
    logic [1:0]  mem_size;
  } ex_t;

  typedef struct {
    ex_t   ex;
    int    cnt;
    int    cnt2;
    string tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0, stall = 1'b0, flush = 1'b0, id_valid = 1'b0;
  logic [31:0] id_PA = '0, id_PB = '0, id_PC = '0;
  logic [11:0] id_imm12_I = '0, id_imm12_S = '0;
  logic [19:0] id_imm20 = '0;
  logic [2:0]  id_S2 = '0;
  logic [3:0]  id_ALU_op = '0;
  logic [4:0]  id_rd = '0;
  logic        id_RF_enable = 1'b0, id_mem_load = 1'b0, id_mem_write = 1'b0, id_mem_se = 1'b0;
  logic [1:0]  id_mem_size = '0;

  logic        ex_valid, ex_RF_enable, ex_mem_load, ex_mem_write, ex_mem_se;
  logic [31:0] ex_PA, ex_PB, ex_PC;
  logic [11:0] ex_imm12_I, ex_imm12_S;
  logic [19:0] ex_imm20;
  logic [2:0]  ex_S2;
  logic [3:0]  ex_ALU_op;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_mem_size;
  logic [15:0] bubble_count;

  logic        s_valid, s_RF_enable, s_mem_load, s_mem_write, s_mem_se;
  logic [31:0] s_PA, s_PB, s_PC;
  logic [11:0] s_imm12_I, s_imm12_S;
  logic [19:0] s_imm20;
  logic [2:0]  s_S2;
  logic [3:0]  s_ALU_op;
  logic [4:0]  s_rd;
  logic [1:0]  s_mem_size;
  logic [1:0]  s_bubble_count;

  always #5 clk = ~clk;

  id_ex_pipeline_reg #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_PA(id_PA), .id_PB(id_PB), .id_PC(id_PC),
    .id_imm12_I(id_imm12_I), .id_imm12_S(id_imm12_S), .id_imm20(id_imm20),
    .id_S2(id_S2), .id_ALU_op(id_ALU_op), .id_rd(id_rd),
    .id_RF_enable(id_RF_enable), .id_mem_load(id_mem_load), .id_mem_write(id_mem_write),
    .id_mem_se(id_mem_se), .id_mem_size(id_mem_size),
    .ex_valid(ex_valid), .ex_PA(ex_PA), .ex_PB(ex_PB), .ex_PC(ex_PC),
    .ex_imm12_I(ex_imm12_I), .ex_imm12_S(ex_imm12_S), .ex_imm20(ex_imm20),
    .ex_S2(ex_S2), .ex_ALU_op(ex_ALU_op), .ex_rd(ex_rd),
    .ex_RF_enable(ex_RF_enable), .ex_mem_load(ex_mem_load), .ex_mem_write(ex_mem_write),
    .ex_mem_se(ex_mem_se), .ex_mem_size(ex_mem_size),
    .bubble_count(bubble_count)
  );

  // Narrow-counter instance exercises saturation with the same stimulus.
  id_ex_pipeline_reg #(.XLEN(32), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_PA(id_PA), .id_PB(id_PB), .id_PC(id_PC),
    .id_imm12_I(id_imm12_I), .id_imm12_S(id_imm12_S), .id_imm20(id_imm20),
    .id_S2(id_S2), .id_ALU_op(id_ALU_op), .id_rd(id_rd),
    .id_RF_enable(id_RF_enable), .id_mem_load(id_mem_load), .id_mem_write(id_mem_write),
    .id_mem_se(id_mem_se), .id_mem_size(id_mem_size),
    .ex_valid(s_valid), .ex_PA(s_PA), .ex_PB(s_PB), .ex_PC(s_PC),
    .ex_imm12_I(s_imm12_I), .ex_imm12_S(s_imm12_S), .ex_imm20(s_imm20),
    .ex_S2(s_S2), .ex_ALU_op(s_ALU_op), .ex_rd(s_rd),
    .ex_RF_enable(s_RF_enable), .ex_mem_load(s_mem_load), .ex_mem_write(s_mem_write),
    .ex_mem_se(s_mem_se), .ex_mem_size(s_mem_size),
    .bubble_count(s_bubble_count)
  );

  ex_t act, act_sat;
  assign act = {ex_valid, ex_PA, ex_PB, ex_PC, ex_imm12_I, ex_imm12_S, ex_imm20, ex_S2,
                ex_ALU_op, ex_rd, ex_RF_enable, ex_mem_load, ex_mem_write, ex_mem_se,
                ex_mem_size};
  assign act_sat = {s_valid, s_PA, s_PB, s_PC, s_imm12_I, s_imm12_S, s_imm20, s_S2,
                    s_ALU_op, s_rd, s_RF_enable, s_mem_load, s_mem_write, s_mem_se,
                    s_mem_size};

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  // Reference model state: what EX should hold and how many bubbles were counted.
  ex_t  m_ex;
  int   m_cnt;
  int   m_cnt2;
  ex_t  bubble;

  task automatic check(input string name, input logic [191:0] actual, input logic [191:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check({e.tag, ":ex"}, 192'(act), 192'(e.ex));
      check({e.tag, ":bubble_count"}, 192'(bubble_count), 192'(e.cnt));
      check({e.tag, ":ex_sat"}, 192'(act_sat), 192'(e.ex));
      check({e.tag, ":bubble_count_sat"}, 192'(s_bubble_count), 192'(e.cnt2));
    end
  end

  task automatic randomize_ids();
    id_PA        = $urandom;
    id_PB        = $urandom;
    id_PC        = $urandom;
    id_imm12_I   = 12'($urandom);
    id_imm12_S   = 12'($urandom);
    id_imm20     = 20'($urandom);
    id_S2        = 3'($urandom_range(0, 5));
    id_ALU_op    = 4'($urandom);
    id_rd        = 5'($urandom);
    id_RF_enable = 1'($urandom);
    id_mem_load  = 1'($urandom);
    id_mem_write = 1'($urandom);
    id_mem_se    = 1'($urandom);
    id_mem_size  = 2'($urandom);
  endtask

  // Drive one edge's controls (id_* already set), advance the model, queue the expectation.
  task automatic cycle(input logic r, input logic s, input logic f, input logic v, input string tag);
    ex_t  in_word;
    exp_t e;
    reset = r; stall = s; flush = f; id_valid = v;
    in_word = {1'b1, id_PA, id_PB, id_PC, id_imm12_I, id_imm12_S, id_imm20, id_S2,
               id_ALU_op, id_rd, id_RF_enable, id_mem_load, id_mem_write, id_mem_se,
               id_mem_size};
    @(posedge clk);
    if (r) begin
      m_ex = bubble; m_cnt = 0; m_cnt2 = 0;
    end else if (f || (!s && !v)) begin
      m_ex   = bubble;
      m_cnt  = (m_cnt  < 65535) ? m_cnt  + 1 : m_cnt;
      m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
    end else if (!s) begin
      m_ex = in_word;
    end
    e.ex = m_ex; e.cnt = m_cnt; e.cnt2 = m_cnt2; e.tag = tag;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    bubble    = '0;
    bubble.s2 = 3'd5;
    m_ex = bubble; m_cnt = 0; m_cnt2 = 0;

    randomize_ids();
    cycle(1'b1, 1'b0, 1'b0, 1'b1, "reset");

    randomize_ids();
    id_PB = 32'hDEADBEEF; id_imm12_I = 12'h800; id_S2 = 3'd1; id_rd = 5'd7;
    cycle(1'b0, 1'b0, 1'b0, 1'b1, "pass");

    randomize_ids();
    id_PC = 32'h100;
    cycle(1'b0, 1'b0, 1'b0, 1'b1, "stall_load");
    id_PC = 32'h104;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, "stall_hold");
    cycle(1'b0, 1'b0, 1'b0, 1'b1, "stall_release");

    randomize_ids();
    id_RF_enable = 1'b1;
    cycle(1'b0, 1'b1, 1'b1, 1'b1, "flush_prio");

    for (int i = 0; i < 4; i++) begin
      randomize_ids();
      cycle(1'b0, 1'b0, 1'b0, 1'b0, "invalid");
    end

    cycle(1'b1, 1'b0, 1'b0, 1'b1, "reset_mid");
    for (int i = 0; i < 5; i++) begin
      randomize_ids();
      cycle(1'b0, 1'b0, 1'b1, 1'b1, "sat_flush");
    end
    randomize_ids();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, "after_flush");
    cycle(1'b1, 1'b1, 1'b1, 1'b0, "reset_prio");

    for (int i = 0; i < 400; i++) begin
      randomize_ids();
      cycle(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 4) != 0), "random");
    end

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_pipeline_reg.md
# id_ex_pipeline_reg

ID/EX pipeline register of the RISC-V PPU. Captures decoded operands, immediate fields, second-operand select and control signals at the end of decode. Presents them to the EX stage, where they feed the second-operand handler and ALU directly. Supports hazard stall (hold), branch/jump flush (bubble insertion), and a saturating bubble counter for pipeline diagnostics.

## Interface
- `XLEN`, default 32: datapath width.
- `CNT_W`, default 16: bubble counter width.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  1  hold current EX contents.
- `flush`  in  1  replace next EX contents with bubble.
- `id_valid`  in  1  decode slot holds a real instruction.
- `id_PA`, `id_PB`, `id_PC`  in  XLEN each  register operands and instruction PC.
- `id_imm12_I`, `id_imm12_S`  in  12 each  raw I/S immediates, unextended.
- `id_imm20`  in  20  raw U immediate.
- `id_S2`  in  3  second-operand select.
- `id_ALU_op`  in  4  ALU function.
- `id_rd`  in  5  destination register.
- `id_RF_enable`, `id_mem_load`, `id_mem_write`, `id_mem_se`  in  1 each  control bits.
- `id_mem_size`  in  2  access size.
- `ex_*`  out  one registered copy of every `id_*` input above, same width, including `ex_valid`.
- `bubble_count`  out  CNT_W  saturating count of bubbles loaded.

## Operation
- Reset is synchronous and active-high: `reset` acts only on a rising `clk` edge.
- Per-edge priority: `reset` > `flush` > `stall` > load.
- `reset`:
  - loads the bubble pattern;
  - clears `bubble_count` to 0.
- `flush`: loads the bubble pattern, even if `stall` is also high.
- `stall` (no flush): all `ex_*` and `bubble_count` hold.
- Load with `id_valid`=1: every `ex_*` equals its `id_*`, and `ex_valid`=1.
- Load with `id_valid`=0: treated as a bubble.
- Bubble pattern (also the reset value of every `ex_*` output):
  - `ex_valid`=0, `ex_RF_enable`=0, `ex_mem_load`=0, `ex_mem_write`=0, `ex_mem_se`=0;
  - `ex_mem_size`=0, `ex_ALU_op`=0, `ex_rd`=0;
  - `ex_PA`=`ex_PB`=`ex_PC`=0, all immediates 0;
  - `ex_S2`=3'b101 (zero select), so the EX second operand is 0.
- `bubble_count`:
  - increments by 1 on each edge where a bubble is loaded by `flush` or by `id_valid`=0 load;
  - reset-loaded bubbles are not counted;
  - saturates at 2^CNT_W−1; no wrap.
- Immediates pass unextended; sign/zero extension belongs to the EX second-operand stage.
- No combinational path from any `id_*` to any `ex_*`. All outputs are registered.

## Timing
- Latency 1 cycle: `id_*` sampled at edge N appears on `ex_*` after edge N.
- Stall held for k cycles freezes the outputs for exactly k edges. Release loads the `id_*` present at the first non-stalled edge.
- `flush` at edge N makes the bubble visible after edge N; valid data resumes at edge N+1 if `flush` drops.
- `reset` mid-stream makes outputs equal the bubble after that edge, regardless of `stall`/`flush`.
- Counter at saturation with flush: stays at max, and the bubble is still loaded.

## Structure
- Shared package `ppu_pkg`:
  - S2 encodings `SEL_PB`=0, `SEL_IMM_I`=1, `SEL_IMM_S`=2, `SEL_IMM_U`=3, `SEL_PC`=4, `SEL_ZERO`=5;
  - ALU op width 4, `ALU_NOP`=0;
  - bubble control constants.
- One sub-module: `sat_counter` (parameter CNT_W; inputs `clk`, `reset`, `inc`, `hold`; output `count`).
- Everything else is flat in this block.

## Test plan
- Reset: assert `reset` 1 cycle with random `id_*` → after the edge, `ex_valid`=0, `ex_S2`=5, all other `ex_*`=0, `bubble_count`=0.
- Pass-through: `id_valid`=1, `id_PB`=0xDEADBEEF, `id_imm12_I`=0x800, `id_S2`=1, `id_rd`=7 → next cycle the same values appear on `ex_*`, with `ex_valid`=1.
- Stall: load PC=0x100, then stall 3 cycles while `id_PC`=0x104 → `ex_PC` stays 0x100 for 3 cycles, then 0x104; `bubble_count` unchanged.
- Flush priority: `stall`=1 and `flush`=1 on the same edge with valid input → bubble loaded, `ex_RF_enable`=0, `bubble_count` +1.
- Invalid decode: 4 cycles of `id_valid`=0 → `ex_valid`=0 each cycle, `bubble_count`=4.
- Saturation: CNT_W=2, 5 flushes → `bubble_count`=3 after the third flush and stays 3.
